// File: rtl/alu_rsv_station_if.sv
// Issue / CDB / dispatch bundle for the ALU reservation station.
// master = decoder/ROB/CDB side, slave = the station itself.
interface alu_rsv_station_if #(
  parameter int ROBID_W = 4,
  parameter int OPID_W  = 6
);
  logic               issue_valid;
  logic [OPID_W-1:0]  issue_op_id;
  logic [31:0]        issue_pc;
  logic [31:0]        issue_imm;
  logic [ROBID_W-1:0] issue_rob_id;
  logic [31:0]        issue_vj;
  logic [31:0]        issue_vk;
  logic               issue_qj_busy;
  logic               issue_qk_busy;
  logic [ROBID_W-1:0] issue_qj;
  logic [ROBID_W-1:0] issue_qk;
  logic               rs_full;

  logic               cdb_alu_valid;
  logic [ROBID_W-1:0] cdb_alu_rob_id;
  logic [31:0]        cdb_alu_value;
  logic               cdb_lsb_valid;
  logic [ROBID_W-1:0] cdb_lsb_rob_id;
  logic [31:0]        cdb_lsb_value;

  logic               alu_valid;
  logic [OPID_W-1:0]  alu_op_id;
  logic [31:0]        alu_pc;
  logic [31:0]        alu_rs1;
  logic [31:0]        alu_rs2;
  logic [31:0]        alu_imm;
  logic [ROBID_W-1:0] alu_rob_id;

  logic               roll_back;

  modport master (
    output issue_valid, issue_op_id, issue_pc, issue_imm, issue_rob_id,
           issue_vj, issue_vk, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value, roll_back,
    input  rs_full, alu_valid, alu_op_id, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );

  modport slave (
    input  issue_valid, issue_op_id, issue_pc, issue_imm, issue_rob_id,
           issue_vj, issue_vk, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value, roll_back,
    output rs_full, alu_valid, alu_op_id, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );
endinterface

// File: rtl/alu_rsv_station.sv
// ALU reservation station: tag wakeup from two CDBs, lowest-index allocate/dispatch.
// Optional ALU_RSV_STATION_PERF_CNT_EN adds dispatch and full-cycle counters.
module alu_rsv_station #(
  parameter int ENTRY_NUM = 8,
  parameter int ROBID_W   = 4,
  parameter int OPID_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  alu_rsv_station_if.slave   io,
  output logic [31:0]        perf_dispatch_cnt,
  output logic [31:0]        perf_full_cnt
);
  localparam int IDX_W = $clog2(ENTRY_NUM);

  typedef struct packed {
    logic               busy;
    logic [OPID_W-1:0]  op_id;
    logic [31:0]        pc;
    logic [31:0]        imm;
    logic [ROBID_W-1:0] rob_id;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic               qj_busy;
    logic [ROBID_W-1:0] qj;
    logic               qk_busy;
    logic [ROBID_W-1:0] qk;
  } ent_t;

  typedef struct packed {
    logic               valid;
    logic [OPID_W-1:0]  op_id;
    logic [31:0]        pc;
    logic [31:0]        rs1;
    logic [31:0]        rs2;
    logic [31:0]        imm;
    logic [ROBID_W-1:0] rob_id;
  } disp_t;

  ent_t [ENTRY_NUM-1:0] ent_q, ent_d;
  disp_t                alu_q, alu_d;
  logic [ENTRY_NUM-1:0] busy_vec;
  logic [IDX_W-1:0]     free_idx, disp_idx;
  logic                 any_rdy, rs_full;

  logic               cdb_a_v, cdb_l_v;
  logic [ROBID_W-1:0] cdb_a_id, cdb_l_id;
  logic [31:0]        cdb_a_val, cdb_l_val;

  assign cdb_a_v   = io.cdb_alu_valid;
  assign cdb_a_id  = io.cdb_alu_rob_id;
  assign cdb_a_val = io.cdb_alu_value;
  assign cdb_l_v   = io.cdb_lsb_valid;
  assign cdb_l_id  = io.cdb_lsb_rob_id;
  assign cdb_l_val = io.cdb_lsb_value;

  // Returns {still_busy, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] wake(input logic busy, input logic [ROBID_W-1:0] tag,
                                       input logic [31:0] v);
    wake = {busy, v};
    if (busy && cdb_a_v && cdb_a_id == tag)      wake = {1'b0, cdb_a_val};
    else if (busy && cdb_l_v && cdb_l_id == tag) wake = {1'b0, cdb_l_val};
  endfunction

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    busy_vec = '0;
    free_idx = '0;
    disp_idx = '0;
    any_rdy  = 1'b0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      busy_vec[i] = ent_q[i].busy;
      if (!ent_q[i].busy) free_idx = IDX_W'(i);
      if (ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
        disp_idx = IDX_W'(i);
        any_rdy  = 1'b1;
      end
    end
  end

  assign rs_full = &busy_vec;

  always_comb begin
    ent_d = ent_q;
    alu_d = alu_q;
    if (rdy) begin
      alu_d.valid = 1'b0;
      if (io.roll_back) begin
        for (int i = 0; i < ENTRY_NUM; i++) ent_d[i].busy = 1'b0;
      end else begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
          if (ent_q[i].busy) begin
            {ent_d[i].qj_busy, ent_d[i].vj} = wake(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
            {ent_d[i].qk_busy, ent_d[i].vk} = wake(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
          end
        end
        // Readiness comes from registered state, so a wakeup this cycle dispatches next cycle.
        if (any_rdy) begin
          alu_d.valid  = 1'b1;
          alu_d.op_id  = ent_q[disp_idx].op_id;
          alu_d.pc     = ent_q[disp_idx].pc;
          alu_d.rs1    = ent_q[disp_idx].vj;
          alu_d.rs2    = ent_q[disp_idx].vk;
          alu_d.imm    = ent_q[disp_idx].imm;
          alu_d.rob_id = ent_q[disp_idx].rob_id;
          ent_d[disp_idx].busy = 1'b0;
        end
        // free_idx is never busy in ent_q, so it cannot collide with the dispatched slot.
        if (io.issue_valid && !rs_full) begin
          ent_d[free_idx].busy    = 1'b1;
          ent_d[free_idx].op_id   = io.issue_op_id;
          ent_d[free_idx].pc      = io.issue_pc;
          ent_d[free_idx].imm     = io.issue_imm;
          ent_d[free_idx].rob_id  = io.issue_rob_id;
          ent_d[free_idx].qj      = io.issue_qj;
          ent_d[free_idx].qk      = io.issue_qk;
          {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = wake(io.issue_qj_busy, io.issue_qj, io.issue_vj);
          {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = wake(io.issue_qk_busy, io.issue_qk, io.issue_vk);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
      alu_q <= '0;
    end else begin
      ent_q <= ent_d;
      alu_q <= alu_d;
    end
  end

  assign io.rs_full    = rs_full;
  assign io.alu_valid  = alu_q.valid;
  assign io.alu_op_id  = alu_q.op_id;
  assign io.alu_pc     = alu_q.pc;
  assign io.alu_rs1    = alu_q.rs1;
  assign io.alu_rs2    = alu_q.rs2;
  assign io.alu_imm    = alu_q.imm;
  assign io.alu_rob_id = alu_q.rob_id;

`ifdef ALU_RSV_STATION_PERF_CNT_EN
  logic [31:0] perf_dispatch_cnt_q, perf_dispatch_cnt_d;
  logic [31:0] perf_full_cnt_q, perf_full_cnt_d;

  always_comb begin
    perf_dispatch_cnt_d = perf_dispatch_cnt_q;
    perf_full_cnt_d     = perf_full_cnt_q;
    if (rdy && !io.roll_back && any_rdy) perf_dispatch_cnt_d = perf_dispatch_cnt_q + 32'd1;
    if (rdy && rs_full)                  perf_full_cnt_d     = perf_full_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dispatch_cnt_q <= '0;
      perf_full_cnt_q     <= '0;
    end else begin
      perf_dispatch_cnt_q <= perf_dispatch_cnt_d;
      perf_full_cnt_q     <= perf_full_cnt_d;
    end
  end

  assign perf_dispatch_cnt = perf_dispatch_cnt_q;
  assign perf_full_cnt     = perf_full_cnt_q;
`else
  assign perf_dispatch_cnt = 32'd0;
  assign perf_full_cnt     = 32'd0;
`endif
endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed bench for alu_rsv_station: expected dispatches go into a scoreboard
// queue, a monitor pops and compares on every alu_valid pulse.
module tb_alu_rsv_station;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic [31:0] pdc, pfc;
  int vectors = 0;
  int miscompares = 0;

  alu_rsv_station_if #(.ROBID_W(4), .OPID_W(6)) io();

  alu_rsv_station #(.ENTRY_NUM(8), .ROBID_W(4), .OPID_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io(io.slave),
    .perf_dispatch_cnt(pdc), .perf_full_cnt(pfc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  rob;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: only edges taken with rdy high and rst low can produce a new pulse.
  always @(posedge clk) begin
    logic rdy_s, rst_s;
    exp_t act, e;
    rdy_s = rdy;
    rst_s = rst;
    #1;
    if (!rst_s && rdy_s && io.alu_valid) begin
      act = '{io.alu_op_id, io.alu_pc, io.alu_rs1, io.alu_rs2, io.alu_imm, io.alu_rob_id};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got %h, expected no dispatch", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL sb_dispatch: got %h, expected %h", act, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [31:0] imm, input logic [3:0] rob,
                       input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk);
    io.issue_valid   = 1'b1;
    io.issue_op_id   = op;
    io.issue_pc      = pc;
    io.issue_vj      = vj;
    io.issue_vk      = vk;
    io.issue_imm     = imm;
    io.issue_rob_id  = rob;
    io.issue_qj_busy = qjb;
    io.issue_qj      = qj;
    io.issue_qk_busy = qkb;
    io.issue_qk      = qk;
    tick();
    io.issue_valid   = 1'b0;
  endtask

  task automatic cdb_off();
    io.cdb_alu_valid = 1'b0;
    io.cdb_lsb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    io.issue_valid = 1'b0; io.issue_op_id = '0; io.issue_pc = '0; io.issue_imm = '0;
    io.issue_rob_id = '0; io.issue_vj = '0; io.issue_vk = '0; io.issue_qj_busy = 1'b0;
    io.issue_qk_busy = 1'b0; io.issue_qj = '0; io.issue_qk = '0;
    io.cdb_alu_valid = 1'b0; io.cdb_alu_rob_id = '0; io.cdb_alu_value = '0;
    io.cdb_lsb_valid = 1'b0; io.cdb_lsb_rob_id = '0; io.cdb_lsb_value = '0;
    io.roll_back = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_rs_full", 32'(io.rs_full), 32'd0);
    chk("reset_alu_valid", 32'(io.alu_valid), 32'd0);
    chk("reset_alu_rob_id", 32'(io.alu_rob_id), 32'd0);
    chk("perf_dispatch_off", pdc, 32'd0);
    chk("perf_full_off", pfc, 32'd0);

    // ADDI with no dependencies
    exp_q.push_back('{6'h13, 32'h100, 32'd5, 32'd0, 32'd7, 4'd3});
    issue(6'h13, 32'h100, 32'd5, 32'd0, 32'd7, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("addi_not_same_cycle", 32'(io.alu_valid), 32'd0);
    tick();
    chk("addi_valid", 32'(io.alu_valid), 32'd1);
    chk("addi_rob", 32'(io.alu_rob_id), 32'd3);
    chk("addi_rs1", io.alu_rs1, 32'd5);
    chk("addi_imm", io.alu_imm, 32'd7);
    tick();
    chk("addi_pulse_end", 32'(io.alu_valid), 32'd0);

    // ADD waiting on tag 2, woken by the ALU CDB
    exp_q.push_back('{6'h33, 32'h104, 32'h10, 32'd1, 32'd0, 4'd4});
    issue(6'h33, 32'h104, 32'd0, 32'd1, 32'd0, 4'd4, 1'b1, 4'd2, 1'b0, 4'd0);
    tick();
    chk("add_waiting", 32'(io.alu_valid), 32'd0);
    io.cdb_alu_valid = 1'b1; io.cdb_alu_rob_id = 4'd2; io.cdb_alu_value = 32'h10;
    tick();
    cdb_off();
    chk("add_no_same_cycle_wake", 32'(io.alu_valid), 32'd0);
    tick();
    chk("add_valid", 32'(io.alu_valid), 32'd1);
    chk("add_rs1", io.alu_rs1, 32'h10);
    chk("add_rs2", io.alu_rs2, 32'd1);
    tick();

    // Issue-time bypass from the LSB CDB
    exp_q.push_back('{6'h33, 32'h108, 32'd2, 32'hAB, 32'd0, 4'd6});
    io.cdb_lsb_valid = 1'b1; io.cdb_lsb_rob_id = 4'd5; io.cdb_lsb_value = 32'hAB;
    issue(6'h33, 32'h108, 32'd2, 32'd0, 32'd0, 4'd6, 1'b0, 4'd0, 1'b1, 4'd5);
    cdb_off();
    tick();
    chk("bypass_valid", 32'(io.alu_valid), 32'd1);
    chk("bypass_rs2", io.alu_rs2, 32'hAB);
    tick();

    // Fill all 8 entries on tag 1, try one more, then release in index order
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{6'h33, 32'h400 + 32'(4 * i), 32'h55, 32'(i), 32'(i), 4'(8 + i)});
      issue(6'h33, 32'h400 + 32'(4 * i), 32'd0, 32'(i), 32'(i), 4'(8 + i), 1'b1, 4'd1, 1'b0, 4'd0);
    end
    chk("full_set", 32'(io.rs_full), 32'd1);
    issue(6'h13, 32'h500, 32'd9, 32'd9, 32'd9, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("full_issue_ignored", 32'(io.rs_full), 32'd1);
    chk("full_no_dispatch", 32'(io.alu_valid), 32'd0);
    io.cdb_alu_valid = 1'b1; io.cdb_alu_rob_id = 4'd1; io.cdb_alu_value = 32'h55;
    tick();
    cdb_off();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_valid", 32'(io.alu_valid), 32'd1);
      chk("drain_order", 32'(io.alu_rob_id), 32'(8 + i));
      if (i == 0) chk("drain_not_full", 32'(io.rs_full), 32'd0);
    end
    tick();
    chk("drain_done", 32'(io.alu_valid), 32'd0);

    // Roll-back flushes waiting entries; issue and CDB in that cycle are ignored
    for (int i = 0; i < 4; i++)
      issue(6'h33, 32'h600, 32'd0, 32'd0, 32'd0, 4'(i), 1'b1, 4'd9, 1'b0, 4'd0);
    io.roll_back = 1'b1;
    io.cdb_alu_valid = 1'b1; io.cdb_alu_rob_id = 4'd9; io.cdb_alu_value = 32'h1;
    issue(6'h13, 32'h700, 32'd1, 32'd1, 32'd1, 4'd12, 1'b0, 4'd0, 1'b0, 4'd0);
    io.roll_back = 1'b0;
    cdb_off();
    chk("rb_alu_valid", 32'(io.alu_valid), 32'd0);
    chk("rb_rs_full", 32'(io.rs_full), 32'd0);
    io.cdb_alu_valid = 1'b1; io.cdb_alu_rob_id = 4'd9; io.cdb_alu_value = 32'h2;
    tick();
    cdb_off();
    tick();
    chk("rb_no_dispatch", 32'(io.alu_valid), 32'd0);
    tick();
    chk("rb_no_dispatch2", 32'(io.alu_valid), 32'd0);

    // Freeze with a ready entry: no dispatch, outputs hold last dispatch (rob 15)
    exp_q.push_back('{6'h13, 32'h800, 32'h77, 32'd3, 32'd1, 4'd7});
    issue(6'h13, 32'h800, 32'h77, 32'd3, 32'd1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_no_dispatch", 32'(io.alu_valid), 32'd0);
      chk("frz_hold_rob", 32'(io.alu_rob_id), 32'd15);
      chk("frz_hold_rs1", io.alu_rs1, 32'h55);
    end
    rdy = 1'b1;
    tick();
    chk("frz_release_valid", 32'(io.alu_valid), 32'd1);
    chk("frz_release_rob", 32'(io.alu_rob_id), 32'd7);
    tick();

    // Reset mid-operation abandons waiting entries
    issue(6'h33, 32'h900, 32'd0, 32'd0, 32'd0, 4'd1, 1'b1, 4'd4, 1'b0, 4'd0);
    issue(6'h33, 32'h904, 32'd0, 32'd0, 32'd0, 4'd2, 1'b0, 4'd0, 1'b1, 4'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rs_full", 32'(io.rs_full), 32'd0);
    chk("rst_alu_valid", 32'(io.alu_valid), 32'd0);
    chk("rst_alu_rob", 32'(io.alu_rob_id), 32'd0);
    chk("rst_alu_rs1", io.alu_rs1, 32'd0);
    chk("rst_alu_pc", io.alu_pc, 32'd0);
    io.cdb_lsb_valid = 1'b1; io.cdb_lsb_rob_id = 4'd4; io.cdb_lsb_value = 32'h3;
    tick();
    cdb_off();
    tick();
    chk("rst_no_dispatch", 32'(io.alu_valid), 32'd0);
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
